// File: rtl/cla_pipe_mod_addsub.sv
// cla_pipe_mod_addsub
//   Pipelined carry-lookahead adder/subtractor with optional modular
//   correction. The operands are processed one SEG-bit segment per pipeline
//   stage. Each stage holds the carry in a register for the next stage. When
//   MOD_EN=1, one more register stage applies the (A +/- B) mod Q correction.
//   All stages advance together on a single global enable (valid/ready with
//   global stall).
//
// Parameters
//   WIDTH   operand/result width, must be a multiple of SEG
//   SEG     CLA segment width = bits resolved per pipeline stage
//   MOD_EN  1: modular result + correction stage; 0: raw sum/difference
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   operand beat present
//   in_ready   beat accepted this cycle (out_ready || !out_valid)
//   op         0 = A + B, 1 = A - B
//   A, B       operands
//   Q          modulus, captured with the beat (unused when MOD_EN=0)
//   out_valid  result beat present
//   out_ready  downstream accepts the result
//   Sum        result
//   Cout       MOD_EN=0: carry-out / no-borrow; MOD_EN=1: correction applied
module cla_pipe_mod_addsub #(
  parameter int unsigned WIDTH  = 128,
  parameter int unsigned SEG    = 32,
  parameter bit          MOD_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] Q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);

  localparam int unsigned NSEG = WIDTH / SEG;

  if (WIDTH % SEG != 0) begin : g_width_check
    $error("cla_pipe_mod_addsub: WIDTH (%0d) must be a multiple of SEG (%0d)", WIDTH, SEG);
  end

  // SEG-bit carry-lookahead add using a parallel-prefix (Kogge-Stone) carry
  // tree. The carry-in is folded into the bit-0 generate term, so any prefix
  // that reaches bit 0 is final and its propagate term is no longer needed.
  function automatic logic [SEG:0] cla_add(input logic [SEG-1:0] a,
                                           input logic [SEG-1:0] b,
                                           input logic           cin);
    logic [SEG-1:0] p;
    logic [SEG-1:0] g;
    logic [SEG-1:0] pp;
    logic [SEG:0]   c;
    p  = a ^ b;
    g  = (a & b) | {{(SEG-1){1'b0}}, p[0] & cin};
    pp = p;
    for (int unsigned d = 1; d < SEG; d = d << 1) begin
      g  = g | (pp & (g << d));
      pp = pp & (pp << d);
    end
    c = {g, cin};
    return {c[SEG], p ^ c[SEG-1:0]};
  endfunction

  logic             en;
  logic [WIDTH-1:0] b_eff;

  assign en       = out_ready || !out_valid;
  assign in_ready = en;
  // Subtraction is A + ~B + 1; the +1 enters as the stage-0 carry-in (op).
  assign b_eff    = op ? ~B : B;

  for (genvar k = 0; k < NSEG; k++) begin : g_st
    // Width of the not-yet-processed operand bits leaving this stage.
    localparam int unsigned HI = WIDTH - (k + 1) * SEG;

    logic                  vld_i;
    logic                  c_i;
    logic [SEG-1:0]        a_i;
    logic [SEG-1:0]        b_i;
    logic [SEG:0]          seg_sum;
    logic [(k+1)*SEG-1:0]  res_d;

    logic                  vld;
    logic                  carry;
    logic [(k+1)*SEG-1:0]  res;

    assign seg_sum = cla_add(a_i, b_i, c_i);

    if (k == 0) begin : g_src
      assign vld_i = in_valid;
      assign c_i   = op;
      assign a_i   = A[SEG-1:0];
      assign b_i   = b_eff[SEG-1:0];
      assign res_d = seg_sum[SEG-1:0];
    end else begin : g_src
      assign vld_i = g_st[k-1].vld;
      assign c_i   = g_st[k-1].carry;
      assign a_i   = g_st[k-1].g_fwd.a_hi[SEG-1:0];
      assign b_i   = g_st[k-1].g_fwd.b_hi[SEG-1:0];
      assign res_d = {seg_sum[SEG-1:0], g_st[k-1].res};
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        vld   <= 1'b0;
        carry <= 1'b0;
        res   <= '0;
      end else if (en) begin
        vld <= vld_i;
        // Data only follows valid beats so bubbles never overwrite results.
        if (vld_i) begin
          carry <= seg_sum[SEG];
          res   <= res_d;
        end
      end
    end

    if (k < NSEG - 1) begin : g_fwd
      logic [HI-1:0] a_hi_d;
      logic [HI-1:0] b_hi_d;
      logic [HI-1:0] a_hi;
      logic [HI-1:0] b_hi;

      if (k == 0) begin : g_fsrc
        assign a_hi_d = A[WIDTH-1:SEG];
        assign b_hi_d = b_eff[WIDTH-1:SEG];
      end else begin : g_fsrc
        assign a_hi_d = g_st[k-1].g_fwd.a_hi[HI+SEG-1:SEG];
        assign b_hi_d = g_st[k-1].g_fwd.b_hi[HI+SEG-1:SEG];
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          a_hi <= '0;
          b_hi <= '0;
        end else if (en && vld_i) begin
          a_hi <= a_hi_d;
          b_hi <= b_hi_d;
        end
      end
    end

    if (MOD_EN) begin : g_mod
      logic             op_d;
      logic [WIDTH-1:0] q_d;
      logic             op_q;
      logic [WIDTH-1:0] q_q;

      if (k == 0) begin : g_msrc
        assign op_d = op;
        assign q_d  = Q;
      end else begin : g_msrc
        assign op_d = g_st[k-1].g_mod.op_q;
        assign q_d  = g_st[k-1].g_mod.q_q;
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          op_q <= 1'b0;
          q_q  <= '0;
        end else if (en && vld_i) begin
          op_q <= op_d;
          q_q  <= q_d;
        end
      end
    end
  end

  if (MOD_EN) begin : g_corr
    logic             v_last;
    logic             c_last;
    logic             op_last;
    logic [WIDTH-1:0] r_last;
    logic [WIDTH-1:0] q_last;
    logic [WIDTH-1:0] corr_sum;
    logic             corr_c;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             vld_q;

    assign v_last  = g_st[NSEG-1].vld;
    assign c_last  = g_st[NSEG-1].carry;
    assign r_last  = g_st[NSEG-1].res;
    assign op_last = g_st[NSEG-1].g_mod.op_q;
    assign q_last  = g_st[NSEG-1].g_mod.q_q;

    // Add: compare the full WIDTH+1-bit sum {C,R} with Q; the low WIDTH bits
    // of {C,R} - Q equal R - Q, so the subtraction can stay WIDTH wide.
    // Subtract: C=0 means a borrow occurred, so fold Q back in.
    always_comb begin
      corr_sum = r_last;
      corr_c   = 1'b0;
      if (op_last) begin
        if (!c_last) begin
          corr_sum = r_last + q_last;
          corr_c   = 1'b1;
        end
      end else if ({c_last, r_last} >= {1'b0, q_last}) begin
        corr_sum = r_last - q_last;
        corr_c   = 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q  <= 1'b0;
        sum_q  <= '0;
        cout_q <= 1'b0;
      end else if (en) begin
        vld_q <= v_last;
        if (v_last) begin
          sum_q  <= corr_sum;
          cout_q <= corr_c;
        end
      end
    end

    assign out_valid = vld_q;
    assign Sum       = sum_q;
    assign Cout      = cout_q;
  end else begin : g_raw
    logic unused_q;
    assign unused_q  = ^Q;

    assign out_valid = g_st[NSEG-1].vld;
    assign Sum       = g_st[NSEG-1].res;
    assign Cout      = g_st[NSEG-1].carry;
  end

endmodule

// File: tb/tb_cla_pipe_mod_addsub.sv
// Testbench for cla_pipe_mod_addsub: one modular instance (MOD_EN=1) and one
// raw instance (MOD_EN=0). Both use WIDTH=128 and SEG=32, and both share
// the same stimulus.
module tb_cla_pipe_mod_addsub;
  localparam int unsigned W = 128;
  localparam logic [W-1:0] QV = 128'd1152921504606830593;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         in_valid;
  logic         op;
  logic         out_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] q;
  logic         rdy_m, vld_m, cout_m;
  logic         rdy_r, vld_r, cout_r;
  logic [W-1:0] sum_m, sum_r;

  int checks = 0;
  int errors = 0;

  cla_pipe_mod_addsub #(.WIDTH(128), .SEG(32), .MOD_EN(1'b1)) dut_mod (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_m), .op(op),
    .A(a), .B(b), .Q(q), .out_valid(vld_m), .out_ready(out_ready),
    .Sum(sum_m), .Cout(cout_m)
  );

  cla_pipe_mod_addsub #(.WIDTH(128), .SEG(32), .MOD_EN(1'b0)) dut_raw (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_r), .op(op),
    .A(a), .B(b), .Q(q), .out_valid(vld_r), .out_ready(out_ready),
    .Sum(sum_r), .Cout(cout_r)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference results written straight from the arithmetic definition
  // (modular results valid for A, B < Q).
  task automatic model(input logic o, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [W-1:0] qv, output logic [W-1:0] rs, output logic rc,
                       output logic [W-1:0] ms, output logic mc);
    logic [W:0] t;
    logic [W:0] m;
    if (!o) begin
      t  = {1'b0, av} + {1'b0, bv};
      rs = t[W-1:0];
      rc = t[W];
      m  = t % {1'b0, qv};
      ms = m[W-1:0];
      mc = (t >= {1'b0, qv});
    end else begin
      rs = av - bv;
      rc = (av >= bv);
      ms = (av >= bv) ? (av - bv) : (av + (qv - bv));
      mc = (av < bv);
    end
  endtask

  function automatic logic [W-1:0] rnd_below_q();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return {64'd0, r % QV[63:0]};
  endfunction

  // Sends one beat into an idle pipeline with out_ready=1 and records the
  // cycle (1 = transfer edge) on which each instance first shows out_valid.
  task automatic one_beat(input logic o, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] qv, output int lat_r, output int lat_m,
                          output logic [W-1:0] s_r, output logic [W-1:0] s_m,
                          output logic c_r, output logic c_m);
    lat_r = 0; lat_m = 0; s_r = '0; s_m = '0; c_r = 1'b0; c_m = 1'b0;
    op = o; a = av; b = bv; q = qv; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      if (vld_r && lat_r == 0) begin lat_r = n; s_r = sum_r; c_r = cout_r; end
      if (vld_m && lat_m == 0) begin lat_m = n; s_m = sum_m; c_m = cout_m; end
      if (n < 8) tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; op = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; q = '0;
    tick(); tick(); tick();
    checks++; if (vld_m !== 1'b0) begin errors++; $display("FAIL reset_out_valid_mod: got %b expected 0", vld_m); end
    checks++; if (sum_m !== '0) begin errors++; $display("FAIL reset_sum_mod: got %0h expected 0", sum_m); end
    checks++; if (cout_m !== 1'b0) begin errors++; $display("FAIL reset_cout_mod: got %b expected 0", cout_m); end
    checks++; if (vld_r !== 1'b0) begin errors++; $display("FAIL reset_out_valid_raw: got %b expected 0", vld_r); end
    checks++; if (sum_r !== '0) begin errors++; $display("FAIL reset_sum_raw: got %0h expected 0", sum_r); end
    checks++; if (cout_r !== 1'b0) begin errors++; $display("FAIL reset_cout_raw: got %b expected 0", cout_r); end
    rst = 1'b0;
    #1;
    checks++; if (rdy_m !== 1'b1) begin errors++; $display("FAIL reset_in_ready_mod: got %b expected 1", rdy_m); end
    checks++; if (rdy_r !== 1'b1) begin errors++; $display("FAIL reset_in_ready_raw: got %b expected 1", rdy_r); end
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_raw_add();
    int lr, lm; logic [W-1:0] sr, sm; logic cr, cm;
    one_beat(1'b0, 128'd1152921504606830593, 128'd128, QV, lr, lm, sr, sm, cr, cm);
    checks++; if (lr != 4) begin errors++; $display("FAIL raw_add_latency: got %0d expected 4", lr); end
    checks++; if (sr !== 128'd1152921504606830721) begin errors++; $display("FAIL raw_add_sum: got %0d expected 1152921504606830721", sr); end
    checks++; if (cr !== 1'b0) begin errors++; $display("FAIL raw_add_cout: got %b expected 0", cr); end
    checks++; if (lm != 5) begin errors++; $display("FAIL mod_add_latency: got %0d expected 5", lm); end
    checks++; if (sm !== 128'd128 || cm !== 1'b1) begin errors++; $display("FAIL mod_add_q_plus_128: got %0d/%b expected 128/1", sm, cm); end
  endtask

  task automatic test_carry_chain();
    int lr, lm; logic [W-1:0] sr, sm; logic cr, cm;
    logic [W-1:0] ones;
    ones = '1;
    one_beat(1'b0, ones, 128'd1, QV, lr, lm, sr, sm, cr, cm);
    checks++; if (sr !== '0 || cr !== 1'b1) begin errors++; $display("FAIL carry_all_segments: got %0h/%b expected 0/1", sr, cr); end
    checks++; if (lr != 4) begin errors++; $display("FAIL carry_all_latency: got %0d expected 4", lr); end
    one_beat(1'b0, 128'hFFFF_FFFF, 128'd1, QV, lr, lm, sr, sm, cr, cm);
    checks++; if (sr !== 128'h1_0000_0000 || cr !== 1'b0) begin errors++; $display("FAIL carry_seg0_to_seg1: got %0h/%b expected 100000000/0", sr, cr); end
  endtask

  task automatic test_mod_ops();
    int lr, lm; logic [W-1:0] sr, sm; logic cr, cm;
    one_beat(1'b0, 128'd1152921504606830592, 128'd5, QV, lr, lm, sr, sm, cr, cm);
    checks++; if (lm != 5) begin errors++; $display("FAIL mod_add_wrap_latency: got %0d expected 5", lm); end
    checks++; if (sm !== 128'd4 || cm !== 1'b1) begin errors++; $display("FAIL mod_add_wrap: got %0d/%b expected 4/1", sm, cm); end
    one_beat(1'b1, 128'd3, 128'd10, QV, lr, lm, sr, sm, cr, cm);
    checks++; if (lm != 5) begin errors++; $display("FAIL mod_sub_borrow_latency: got %0d expected 5", lm); end
    checks++; if (sm !== 128'd1152921504606830586 || cm !== 1'b1) begin errors++; $display("FAIL mod_sub_borrow: got %0d/%b expected 1152921504606830586/1", sm, cm); end
    checks++; if (sr !== 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFF9 || cr !== 1'b0) begin errors++; $display("FAIL raw_sub_borrow: got %0h/%b expected fff..ff9/0", sr, cr); end
    one_beat(1'b1, 128'd10, 128'd3, QV, lr, lm, sr, sm, cr, cm);
    checks++; if (lm != 5) begin errors++; $display("FAIL mod_sub_plain_latency: got %0d expected 5", lm); end
    checks++; if (sm !== 128'd7 || cm !== 1'b0) begin errors++; $display("FAIL mod_sub_plain: got %0d/%b expected 7/0", sm, cm); end
    checks++; if (sr !== 128'd7 || cr !== 1'b1) begin errors++; $display("FAIL raw_sub_no_borrow: got %0d/%b expected 7/1", sr, cr); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] ers[$]; logic erc[$]; logic [W-1:0] ems[$]; logic emc[$];
    logic [W-1:0] av, bv, rs, ms; logic o, rc, mc;
    int got_m = 0, got_r = 0, first_m = -1, last_m = -1, first_r = -1, last_r = -1;
    out_ready = 1'b1;
    for (int n = 0; n < 112; n++) begin
      if (n < 100) begin
        av = rnd_below_q(); bv = rnd_below_q(); o = 1'($urandom_range(0, 1));
        model(o, av, bv, QV, rs, rc, ms, mc);
        ers.push_back(rs); erc.push_back(rc); ems.push_back(ms); emc.push_back(mc);
        op = o; a = av; b = bv; q = QV; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      if (vld_m) begin
        if (first_m < 0) first_m = n;
        last_m = n; got_m++;
        checks++;
        if (ems.size() == 0) begin errors++; $display("FAIL b2b_mod_extra: got beat %0d expected none", got_m); end
        else begin
          ms = ems.pop_front(); mc = emc.pop_front();
          if (sum_m !== ms || cout_m !== mc) begin errors++; $display("FAIL b2b_mod_beat%0d: got %0h/%b expected %0h/%b", got_m, sum_m, cout_m, ms, mc); end
        end
      end
      if (vld_r) begin
        if (first_r < 0) first_r = n;
        last_r = n; got_r++;
        checks++;
        if (ers.size() == 0) begin errors++; $display("FAIL b2b_raw_extra: got beat %0d expected none", got_r); end
        else begin
          rs = ers.pop_front(); rc = erc.pop_front();
          if (sum_r !== rs || cout_r !== rc) begin errors++; $display("FAIL b2b_raw_beat%0d: got %0h/%b expected %0h/%b", got_r, sum_r, cout_r, rs, rc); end
        end
      end
      tick();
    end
    checks++; if (got_m != 100 || last_m - first_m + 1 != 100) begin errors++; $display("FAIL b2b_mod_continuous: got %0d beats over %0d cycles expected 100/100", got_m, last_m - first_m + 1); end
    checks++; if (got_r != 100 || last_r - first_r + 1 != 100) begin errors++; $display("FAIL b2b_raw_continuous: got %0d beats over %0d cycles expected 100/100", got_r, last_r - first_r + 1); end
    checks++; if (first_m != 5 || first_r != 4) begin errors++; $display("FAIL b2b_first_latency: got mod %0d raw %0d expected 5 and 4", first_m, first_r); end
  endtask

  // Backpressure is checked on the modular instance; the raw instance sees
  // the same in_valid but a different in_ready, so its stream is not tracked.
  task automatic test_backpressure();
    logic [W-1:0] ems[$]; logic emc[$];
    logic [W-1:0] av, bv, rs, ms, sum_prev; logic o, rc, mc, stall_prev, cout_prev;
    int sent = 0, recv = 0;
    stall_prev = 1'b0; sum_prev = '0; cout_prev = 1'b0;
    av = rnd_below_q(); bv = rnd_below_q(); o = 1'($urandom_range(0, 1));
    for (int cyc = 0; cyc < 600 && recv < 60; cyc++) begin
      out_ready = 1'($urandom_range(0, 1));
      if (sent < 60) begin op = o; a = av; b = bv; q = QV; in_valid = 1'b1; end
      else in_valid = 1'b0;
      #1;
      checks++;
      if (rdy_m !== (out_ready || !vld_m)) begin errors++; $display("FAIL bp_in_ready cyc%0d: got %b expected %b", cyc, rdy_m, out_ready || !vld_m); end
      if (stall_prev) begin
        checks++;
        if (vld_m !== 1'b1 || sum_m !== sum_prev || cout_m !== cout_prev) begin errors++; $display("FAIL bp_stall_hold cyc%0d: got %b/%0h/%b expected 1/%0h/%b", cyc, vld_m, sum_m, cout_m, sum_prev, cout_prev); end
      end
      if (vld_m && out_ready) begin
        recv++;
        checks++;
        if (ems.size() == 0) begin errors++; $display("FAIL bp_extra_beat: got beat %0d expected none", recv); end
        else begin
          ms = ems.pop_front(); mc = emc.pop_front();
          if (sum_m !== ms || cout_m !== mc) begin errors++; $display("FAIL bp_beat%0d: got %0h/%b expected %0h/%b", recv, sum_m, cout_m, ms, mc); end
        end
      end
      if (in_valid && rdy_m) begin
        model(o, av, bv, QV, rs, rc, ms, mc);
        ems.push_back(ms); emc.push_back(mc);
        sent++;
        av = rnd_below_q(); bv = rnd_below_q(); o = 1'($urandom_range(0, 1));
      end
      stall_prev = vld_m && !out_ready; sum_prev = sum_m; cout_prev = cout_m;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (recv != 60) begin errors++; $display("FAIL bp_beat_count: got %0d expected 60", recv); end
    for (int n = 0; n < 8; n++) begin
      if (vld_m) begin checks++; errors++; $display("FAIL bp_trailing_beat: got out_valid=1 expected 0"); end
      tick();
    end
  endtask

  task automatic test_reset_mid_stream();
    int lr, lm; logic [W-1:0] sr, sm; logic cr, cm;
    logic seen_m = 1'b0, seen_r = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      op = 1'b0; a = rnd_below_q(); b = rnd_below_q(); q = QV; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int n = 0; n < 8; n++) begin
      if (vld_m) seen_m = 1'b1;
      if (vld_r) seen_r = 1'b1;
      tick();
    end
    checks++; if (seen_m !== 1'b0) begin errors++; $display("FAIL rst_mid_flush_mod: got out_valid=1 expected 0"); end
    checks++; if (seen_r !== 1'b0) begin errors++; $display("FAIL rst_mid_flush_raw: got out_valid=1 expected 0"); end
    one_beat(1'b1, 128'd100, 128'd58, QV, lr, lm, sr, sm, cr, cm);
    checks++; if (lm != 5 || lr != 4) begin errors++; $display("FAIL rst_mid_latency: got mod %0d raw %0d expected 5 and 4", lm, lr); end
    checks++; if (sm !== 128'd42 || cm !== 1'b0) begin errors++; $display("FAIL rst_mid_mod_value: got %0d/%b expected 42/0", sm, cm); end
    checks++; if (sr !== 128'd42 || cr !== 1'b1) begin errors++; $display("FAIL rst_mid_raw_value: got %0d/%b expected 42/1", sr, cr); end
  endtask

  initial begin
    test_reset();
    test_raw_add();
    test_carry_chain();
    test_mod_ops();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_stream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cla_pipe_mod_addsub.md
# cla_pipe_mod_addsub

Parametrised, pipelined carry-lookahead adder/subtractor with optional modular correction. It is the successor to the flat 128-bit combinational CLA adder. The block splits the operand into SEG-bit CLA segments, one segment per pipeline stage, and registers the carry between stages. A valid/ready handshake with global stall is added. It feeds the NTT butterfly datapath, where (A±B) mod Q is needed at full clock rate.

## Interface
- WIDTH, 128: operand/result width in bits; must be a multiple of SEG
- SEG, 32: CLA segment width, which is also the bits resolved per pipeline stage; NSEG = WIDTH/SEG
- MOD_EN, 1: 1 = modular result and correction stage present; 0 = raw sum/difference, no correction stage
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand beat present
- in_ready  output  1  block accepts a beat this cycle
- op  input  1  0 = add, 1 = subtract (A − B)
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- Q  input  WIDTH  modulus, captured with the beat; ignored when MOD_EN=0
- out_valid  output  1  result beat present
- out_ready  input  1  downstream accepts result
- Sum  output  WIDTH  result
- Cout  output  1  MOD_EN=0: add carry-out, or subtract no-borrow flag (1 = A ≥ B); MOD_EN=1: 1 when correction was applied

## Operation
- Transfer on input when in_valid && in_ready; on output when out_valid && out_ready.
- Global enable: en = out_ready || !out_valid; in_ready = en. All stage registers and valid bits advance only when en=1; otherwise everything holds.
- Subtract is implemented as A + ~B + 1: carry-in of stage 0 = op.
- Stage k (0..NSEG−1):
  - computes bits [k·SEG +: SEG] with a SEG-bit CLA, using the registered carry from stage k−1;
  - forwards the not-yet-processed upper operand slices, op and Q alongside (delay-matched);
  - the stage k result slice is carried forward to the output.
- After stage NSEG−1: raw result R (WIDTH bits) and carry C.
- MOD_EN=0: Sum = R, Cout = C.
- MOD_EN=1, correction stage (one extra register stage):
  - add: T = {C,R}, WIDTH+1 bits; if T ≥ Q then Sum = T − Q and Cout = 1; else Sum = R and Cout = 0. Result truncated to WIDTH.
  - subtract: if C=0 (borrow) then Sum = R + Q mod 2^WIDTH and Cout = 1; else Sum = R and Cout = 0.
- Modular results are correct for A, B < Q. Outside that range the formulas above still define the output bit-exactly.
- WIDTH % SEG ≠ 0: elaboration-time error via generate-time check, no silent truncation.

## Timing
- Latency L = NSEG + MOD_EN cycles from input transfer to out_valid, in the absence of stalls. Defaults: L = 5.
- Throughput 1 beat/cycle while out_ready=1; no bubbles inserted.
- Stall: while out_valid=1 and out_ready=0, Sum/Cout/out_valid are held stable and in_ready=0.
- Output asserted only from registers. in_ready is combinational from out_ready and out_valid.
- Reset values:
  - out_valid=0, Sum=0, Cout=0;
  - all internal valid bits and carry registers 0;
  - in_ready=1 in the first cycle after reset.
- Reset mid-operation discards all in-flight beats. No output appears for beats accepted before rst. The first post-reset input appears after exactly L cycles.
- Simultaneous input transfer and output stall is impossible by construction (in_ready=0 during stall).
- Bubbles (in_valid=0) propagate as invalid stages. Their data contents are don't-care but must not reach Sum while out_valid=0: Sum holds its last valid value.

## Test plan
- Raw add, MOD_EN=0, defaults, op=0: A=1152921504606830593, B=128 → after 4 cycles Sum=1152921504606830721, Cout=0.
- Carry across every segment, MOD_EN=0, op=0: A=2^128−1, B=1 → Sum=0, Cout=1. Also A=2^32−1, B=1 → Sum=2^32, Cout=0; this checks the inter-stage carry.
- Modular add/sub, MOD_EN=1, Q=1152921504606830593:
  - op=0, A=Q−1, B=5 → Sum=4, Cout=1.
  - op=1, A=3, B=10 → Sum=Q−7, Cout=1.
  - op=1, A=10, B=3 → Sum=7, Cout=0.
  - Each result appears after 5 cycles.
- Back-to-back streaming: 100 random beats (A, B < Q, random op) with out_ready=1 → 100 consecutive out_valid cycles; results match the reference model in order.
- Backpressure: stream with out_ready toggling randomly at 50% → no beat lost or duplicated; Sum is stable while stalled; in_ready = out_ready || !out_valid every cycle.
- Reset mid-stream: accept 3 beats, assert rst for 1 cycle → out_valid stays 0 for those beats. The next accepted beat appears after exactly L cycles with the correct value.
